// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, operands shifted LSB-first, carry
// held in a flop between bits. Result appears WIDTH cycles after start.

// Single-bit full adder slice.
module one_bit_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    one_bit_adder u_slice (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;

        // Shift-then-insert form covers WIDTH=1 without a zero-width slice.
        res_next            = res_sr_q >> 1;
        res_next[WIDTH-1]   = fa_sum;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    carry_d  = bus.c_in;
                    cnt_d    = '0;
                    res_sr_d = '0;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_next;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = res_next;
                    c_out_d = fa_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
        end
    end

    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 8, 1 and 32.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_aux = 1'b1;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(1))  bus1 ();
    serial_adder_if #(.WIDTH(32)) bus32 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst_aux),
        .bus (bus1.slave)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst_aux),
        .bus (bus32.slave)
    );

    int checks = 0;
    int errors = 0;
    bit fin1 = 1'b0;
    bit fin32 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the 8-bit instance: an accepted request
    // keeps the unit busy for 8 cycles, then shows a+b+c_in for one cycle.
    int       m_rem;
    logic     m_done;
    logic [7:0] m_sum;
    logic     m_cout;
    logic [8:0] m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_sum  <= 8'h00;
            m_cout <= 1'b0;
            m_pend <= 9'h000;
        end else if (m_rem != 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                {m_cout, m_sum} <= m_pend;
            end
        end else begin
            m_done <= 1'b0;
            if (bus8.start) begin
                m_rem  <= 8;
                m_pend <= 9'(bus8.a) + 9'(bus8.b) + 9'(bus8.c_in);
            end
        end
    end

    // Cycle-by-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        chk("busy", 64'(bus8.busy), 64'(m_rem != 0));
        chk("done", 64'(bus8.done), 64'(m_done));
        chk("sum", 64'(bus8.sum), 64'(m_sum));
        chk("c_out", 64'(bus8.c_out), 64'(m_cout));
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.a = a;
        bus8.b = b;
        bus8.c_in = c;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a = 8'hxx;
        bus8.b = 8'hxx;
        bus8.c_in = 1'bx;
    endtask

    // Returns the number of edges after the accepting edge until done is seen.
    task automatic wait_done8(input string name, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus8.done) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            errors++;
            checks++;
            $display("FAIL %s: got timeout expected done within 20 cycles", name);
        end
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic ec);
        int n;
        issue8(a, b, c);
        wait_done8(name, n);
        chk({name, "_lat"}, 64'(n), 64'd8);
        chk({name, "_sum"}, 64'(bus8.sum), 64'(es));
        chk({name, "_cout"}, 64'(bus8.c_out), 64'(ec));
    endtask

    // WIDTH=1: exhaustive inputs, latency of one edge.
    initial begin
        int n;
        bus1.start = 1'b0;
        bus1.a = '0;
        bus1.b = '0;
        bus1.c_in = 1'b0;
        wait (rst_aux == 1'b0);
        @(posedge clk);
        #1;
        chk("w1_rst_sum", 64'(bus1.sum), 64'd0);
        for (int k = 7; k >= 0; k--) begin
            logic [2:0] v;
            v = 3'(k);
            bus1.a = v[2];
            bus1.b = v[1];
            bus1.c_in = v[0];
            bus1.start = 1'b1;
            @(posedge clk);
            #1;
            bus1.start = 1'b0;
            n = -1;
            for (int i = 1; i <= 6; i++) begin
                @(posedge clk);
                #1;
                if (bus1.done) begin
                    n = i;
                    break;
                end
            end
            chk("w1_lat", 64'(n), 64'd1);
            chk("w1_res", 64'({bus1.c_out, bus1.sum}), 64'(2'(v[2]) + 2'(v[1]) + 2'(v[0])));
        end
        fin1 = 1'b1;
    end

    // WIDTH=32: random sweep, each new request issued in the done cycle.
    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        int          n;
        bus32.start = 1'b0;
        bus32.a = '0;
        bus32.b = '0;
        bus32.c_in = 1'b0;
        wait (rst_aux == 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            if (k == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0000; rc = 1'b1; end
            bus32.a = ra;
            bus32.b = rb;
            bus32.c_in = rc;
            bus32.start = 1'b1;
            @(posedge clk);
            #1;
            bus32.start = 1'b0;
            n = -1;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                #1;
                if (bus32.done) begin
                    n = i;
                    break;
                end
            end
            chk("w32_lat", 64'(n), 64'd32);
            chk("w32_res", 64'({bus32.c_out, bus32.sum}), 64'(33'(ra) + 33'(rb) + 33'(rc)));
        end
        fin32 = 1'b1;
    end

    // Main directed sequence on the 8-bit instance.
    initial begin
        int n;
        bit ok;
        bus8.start = 1'b0;
        bus8.a = 8'h00;
        bus8.b = 8'h00;
        bus8.c_in = 1'b0;
        #23;
        chk("rst_busy", 64'(bus8.busy), 64'd0);
        chk("rst_done", 64'(bus8.done), 64'd0);
        chk("rst_sum", 64'(bus8.sum), 64'd0);
        chk("rst_cout", 64'(bus8.c_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_aux = 1'b0;
        @(posedge clk);
        #1;

        op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        @(posedge clk);
        #1;
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("add_7f_80_c", 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1);
        op8("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

        // Start pulse during SHIFT must be ignored.
        @(posedge clk);
        #1;
        issue8(8'h03, 8'h04, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("held_during_busy", 64'(bus8.sum), 64'hFF);
        issue8(8'hFF, 8'hFF, 1'b0);
        wait_done8("ignore_start", n);
        chk("ignore_sum", 64'(bus8.sum), 64'h07);
        chk("ignore_cout", 64'(bus8.c_out), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("no_second_done", 64'(bus8.done), 64'd0);
        end

        // Asynchronous reset mid-operation.
        issue8(8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus8.busy), 64'd0);
        chk("arst_done", 64'(bus8.done), 64'd0);
        chk("arst_sum", 64'(bus8.sum), 64'd0);
        chk("arst_cout", 64'(bus8.c_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("arst_no_done", 64'(bus8.done), 64'd0);
        end
        op8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Back-to-back: next request accepted in the DONE cycle.
        @(posedge clk);
        #1;
        op8("b2b_first", 8'h22, 8'h11, 1'b0, 8'h33, 1'b0);
        op8("b2b_second", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

        // Random sweep at WIDTH=8, back-to-back.
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(1, 0));
            issue8(ra, rb, rc);
            wait_done8("rand8", n);
            chk("rand8_res", 64'({bus8.c_out, bus8.sum}), 64'(9'(ra) + 9'(rb) + 9'(rc)));
        end

        ok = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            if (fin1 && fin32) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL aux_sweeps: got timeout expected completion");
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
